// File: rtl/obstacle_scroller.sv
// Obstacle field for the runner game: spawns, scrolls and scores up to two obstacles, flags dino hits.
// Optional: define SPEEDUP_EN to double the scroll speed once score reaches SPEEDUP_SCORE.
`timescale 1ns/1ps
module obstacle_scroller #(
   parameter int          TICK_DIV      = 250000,
   parameter int          SCREEN_W      = 640,
   parameter int          DINO_X        = 64,
   parameter int          DINO_W        = 16,
   parameter int          OBS_W         = 8,
   parameter int          MIN_GAP       = 160,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          SPEEDUP_SCORE = 50
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       game_status,
   input  logic [5:0] dinosaur_height,
   output logic       obs0_valid,
   output logic       obs1_valid,
   output logic [9:0] obs0_x,
   output logic [9:0] obs1_x,
   output logic [5:0] obs0_h,
   output logic [5:0] obs1_h,
   output logic [13:0] score,
   output logic       tick,
   output logic       collision
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [10:0] DINO_L = 11'(DINO_X);
   localparam logic [10:0] DINO_R = 11'(DINO_X + DINO_W);
`ifdef SPEEDUP_EN
   localparam bit SPEEDUP_ON = 1'b1;
`else
   localparam bit SPEEDUP_ON = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

   state_t           state;
   logic [15:0]      lfsr;
   logic [CNT_W-1:0] tick_cnt;
   logic [9:0]       gap;
   logic             valid [2];
   logic [9:0]       x     [2];
   logic [5:0]       h     [2];

   logic             wrap;
   logic [1:0]       hit;
   logic [1:0]       speed;
   logic             nx_valid [2];
   logic [9:0]       nx_x     [2];
   logic [5:0]       nx_h     [2];
   logic [13:0]      nx_score;
   logic [10:0]      gap_sum;
   logic [9:0]       nx_gap;
   logic             spawn;

   assign wrap      = (tick_cnt == CNT_W'(TICK_DIV - 1));
   assign tick      = (state == RUN) && wrap;
   assign collision = (state == RUN) && (|hit);
   assign speed     = (SPEEDUP_ON && (score >= 14'(SPEEDUP_SCORE))) ? 2'd2 : 2'd1;

   // Overlap test on registered slots; right edges computed at 11 bits so they cannot wrap.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         hit[i] = valid[i] && ({1'b0, x[i]} < DINO_R) &&
                  (({1'b0, x[i]} + 11'(OBS_W)) > DINO_L) && (dinosaur_height < h[i]);
      end
   end

   // Outcome of one scroll tick: exits/scroll, gap accumulation, then spawn into a pre-tick free slot.
   always_comb begin
      nx_score = score;
      for (int i = 0; i < 2; i++) begin
         nx_valid[i] = valid[i];
         nx_x[i]     = x[i];
         nx_h[i]     = h[i];
         if (valid[i]) begin
            if (x[i] < 10'(speed)) begin
               nx_valid[i] = 1'b0;
               if (nx_score != 14'd9999) nx_score = nx_score + 14'd1;
            end else begin
               nx_x[i] = x[i] - 10'(speed);
            end
         end
      end
      gap_sum = {1'b0, gap} + 11'(speed);
      nx_gap  = gap_sum[10] ? 10'd1023 : gap_sum[9:0];
      spawn   = ({1'b0, nx_gap} >= (11'(MIN_GAP) + {5'd0, lfsr[5:0]})) && (!valid[0] || !valid[1]);
      if (spawn) begin
         if (!valid[0]) begin
            nx_valid[0] = 1'b1;
            nx_x[0]     = 10'(SCREEN_W - 1);
            nx_h[0]     = lfsr[6] ? 6'd12 : 6'd8;
         end else begin
            nx_valid[1] = 1'b1;
            nx_x[1]     = 10'(SCREEN_W - 1);
            nx_h[1]     = lfsr[6] ? 6'd12 : 6'd8;
         end
         nx_gap = 10'd0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         lfsr     <= LFSR_SEED;
         tick_cnt <= '0;
         gap      <= '0;
         score    <= '0;
         for (int i = 0; i < 2; i++) begin
            valid[i] <= 1'b0;
            x[i]     <= '0;
            h[i]     <= '0;
         end
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         case (state)
            IDLE: begin
               if (game_status) begin
                  state    <= RUN;
                  score    <= '0;
                  tick_cnt <= '0;
                  gap      <= 10'd1023;
                  for (int i = 0; i < 2; i++) valid[i] <= 1'b0;
               end
            end
            RUN: begin
               // A hit freezes everything, including a tick landing in the same cycle.
               if (collision) begin
                  state <= HIT;
               end else if (!game_status) begin
                  state <= IDLE;
                  for (int i = 0; i < 2; i++) valid[i] <= 1'b0;
               end else begin
                  tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
                  if (wrap) begin
                     score <= nx_score;
                     gap   <= nx_gap;
                     for (int i = 0; i < 2; i++) begin
                        valid[i] <= nx_valid[i];
                        x[i]     <= nx_x[i];
                        h[i]     <= nx_h[i];
                     end
                  end
               end
            end
            HIT: begin
               if (!game_status) begin
                  state <= IDLE;
                  for (int i = 0; i < 2; i++) valid[i] <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign obs0_valid = valid[0];
   assign obs1_valid = valid[1];
   assign obs0_x     = x[0];
   assign obs1_x     = x[1];
   assign obs0_h     = h[0];
   assign obs1_h     = h[1];

endmodule

// File: tb/tb_obstacle_scroller.sv
// Scoreboard bench for obstacle_scroller: a cycle model predicts every output, plus directed scenario checks.
`timescale 1ns/1ps
module tb_obstacle_scroller;

   localparam int          TICK_DIV = 4;
   localparam int          SCREEN_W = 640;
   localparam int          DINO_X   = 64;
   localparam int          DINO_W   = 16;
   localparam int          OBS_W    = 8;
   localparam int          MIN_GAP  = 16;
   localparam logic [15:0] SEED     = 16'hACE1;
   localparam int          SPD      = 1;
`ifdef SPEEDUP_EN
   localparam bit SPEEDUP_ON = 1'b1;
   localparam int EXP_S      = 2;
`else
   localparam bit SPEEDUP_ON = 1'b0;
   localparam int EXP_S      = 1;
`endif

   logic        CLK, RST, game_status;
   logic [5:0]  dinosaur_height;
   logic        obs0_valid, obs1_valid;
   logic [9:0]  obs0_x, obs1_x;
   logic [5:0]  obs0_h, obs1_h;
   logic [13:0] score;
   logic        tick, collision;

   obstacle_scroller #(
      .TICK_DIV(TICK_DIV), .SCREEN_W(SCREEN_W), .DINO_X(DINO_X), .DINO_W(DINO_W),
      .OBS_W(OBS_W), .MIN_GAP(MIN_GAP), .LFSR_SEED(SEED), .SPEEDUP_SCORE(SPD)
   ) dut (
      .CLK(CLK), .RST(RST), .game_status(game_status), .dinosaur_height(dinosaur_height),
      .obs0_valid(obs0_valid), .obs1_valid(obs1_valid), .obs0_x(obs0_x), .obs1_x(obs1_x),
      .obs0_h(obs0_h), .obs1_h(obs1_h), .score(score), .tick(tick), .collision(collision)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   logic [49:0] exp_q [$];
   logic        cur_gs;
   logic [5:0]  cur_dh;

   // Reference model state
   int          m_state;
   logic [15:0] m_lfsr;
   int          m_cnt, m_gap, m_score;
   bit          m_v [2];
   int          m_x [2];
   int          m_h [2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [49:0] dut_vec();
      return {obs0_valid, obs0_x, obs0_h, obs1_valid, obs1_x, obs1_h, score, tick, collision};
   endfunction

   task automatic model_reset();
      m_state = 0; m_lfsr = SEED; m_cnt = 0; m_gap = 0; m_score = 0;
      for (int i = 0; i < 2; i++) begin m_v[i] = 0; m_x[i] = 0; m_h[i] = 0; end
   endtask

   function automatic bit model_hit(input int dh);
      if (m_state != 1) return 1'b0;
      for (int i = 0; i < 2; i++)
         if (m_v[i] && (m_x[i] < DINO_X + DINO_W) && (m_x[i] + OBS_W > DINO_X) && (dh < m_h[i]))
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_expect(input logic [5:0] dh, output logic [49:0] e);
      bit t;
      t = (m_state == 1) && (m_cnt == TICK_DIV - 1);
      e = {m_v[0], 10'(m_x[0]), 6'(m_h[0]), m_v[1], 10'(m_x[1]), 6'(m_h[1]),
           14'(m_score), t, model_hit(int'(dh))};
   endtask

   task automatic model_advance(input logic gs, input logic [5:0] dh);
      bit hitv, wrapv;
      bit fr [2];
      int s, k;
      logic [15:0] l;
      l     = m_lfsr;
      hitv  = model_hit(int'(dh));
      wrapv = (m_cnt == TICK_DIV - 1);
      m_lfsr = {l[14:0], ^(l & 16'hB400)};
      case (m_state)
         0: if (gs) begin
               m_state = 1; m_score = 0; m_cnt = 0; m_gap = 1023;
               m_v[0] = 0; m_v[1] = 0;
            end
         1: if (hitv) m_state = 2;
            else if (!gs) begin m_state = 0; m_v[0] = 0; m_v[1] = 0; end
            else begin
               m_cnt = wrapv ? 0 : m_cnt + 1;
               if (wrapv) begin
                  s = (SPEEDUP_ON && m_score >= SPD) ? 2 : 1;
                  fr[0] = !m_v[0]; fr[1] = !m_v[1];
                  for (int i = 0; i < 2; i++) begin
                     if (m_v[i]) begin
                        if (m_x[i] < s) begin
                           m_v[i] = 0;
                           if (m_score < 9999) m_score++;
                        end else m_x[i] -= s;
                     end
                  end
                  m_gap = (m_gap + s > 1023) ? 1023 : m_gap + s;
                  if (m_gap >= MIN_GAP + int'(l[5:0]) && (fr[0] || fr[1])) begin
                     k = fr[0] ? 0 : 1;
                     m_v[k] = 1; m_x[k] = SCREEN_W - 1; m_h[k] = l[6] ? 12 : 8;
                     m_gap = 0;
                  end
               end
            end
         default: if (!gs) begin m_state = 0; m_v[0] = 0; m_v[1] = 0; end
      endcase
   endtask

   // One clock cycle: drive at negedge, predict, sample 1ns later, well before the posedge.
   task automatic step(input logic r);
      logic [49:0] e;
      @(negedge CLK);
      game_status = cur_gs; dinosaur_height = cur_dh; RST = r;
      if (r) model_reset();
      model_expect(cur_dh, e);
      exp_q.push_back(e);
      if (!r) model_advance(cur_gs, cur_dh);
      #1;
      e = exp_q.pop_front();
      chk("cycle", 64'(dut_vec()), 64'(e));
   endtask

   task automatic wait_tick(output int n);
      n = -1;
      for (int k = 1; k <= 3 * TICK_DIV; k++) begin
         step(1'b0);
         if (tick) begin n = k; break; end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, a, b;
      bit found;
      RST = 1'b1; game_status = 1'b0; dinosaur_height = '0;
      cur_gs = 1'b0; cur_dh = 6'd0;

      // Reset and idle
      step(1'b1); step(1'b1);
      chk("rst_out", 64'(dut_vec()), 64'd0);
      step(1'b0); step(1'b0);
      chk("idle_out", 64'(dut_vec()), 64'd0);

      // Start, first spawn, first scroll, no early second spawn
      cur_gs = 1'b1; cur_dh = 6'd12;
      step(1'b0);
      wait_tick(n);
      chk("first_tick_cycle", 64'(n), 64'd4);
      step(1'b0);
      chk("spawn_valid", 64'(obs0_valid), 64'd1);
      chk("spawn_x", 64'(obs0_x), 64'd639);
      chk("spawn_h_ok", 64'(obs0_h == 6'd8 || obs0_h == 6'd12), 64'd1);
      chk("spawn_one_slot", 64'(obs1_valid), 64'd0);
      wait_tick(n);
      step(1'b0);
      chk("scroll_1px", 64'(obs0_x), 64'd638);
      for (int k = 0; k < 200 && obs0_x != 10'd624; k++) step(1'b0);
      chk("reach_624", 64'(obs0_x), 64'd624);
      chk("no_early_spawn", 64'(obs1_valid), 64'd0);

      // Obstacle passes under a high dino and exits at x=0
      found = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         step(1'b0);
         if (tick && obs0_valid && obs0_x == 10'd0) begin
            found = 1'b1;
            chk("score_before_exit", 64'(score), 64'd0);
            step(1'b0);
            chk("exit_valid", 64'(obs0_valid), 64'd0);
            chk("exit_score", 64'(score), 64'd1);
            break;
         end
      end
      chk("exit_seen", 64'(found), 64'd1);

      // Scroll step after the first clear (doubled with SPEEDUP_EN)
      chk("slot1_live", 64'(obs1_valid), 64'd1);
      n = -1;
      for (int k = 0; k < 3 * TICK_DIV; k++) begin
         step(1'b0);
         if (tick) begin n = k; break; end
      end
      a = int'(obs1_x);
      step(1'b0);
      b = int'(obs1_x);
      chk("speed_tick_seen", 64'(n >= 0), 64'd1);
      chk("speed_step", 64'(a - b), 64'(EXP_S));
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         step(1'b0);
         if (tick && obs1_valid && int'(obs1_x) < EXP_S) begin
            found = 1'b1;
            step(1'b0);
            chk("exit_fast", 64'(obs1_valid), 64'd0);
            break;
         end
      end
      chk("exit_fast_seen", 64'(found), 64'd1);

      // Stop in RUN: slots cleared, score kept
      cur_gs = 1'b0;
      step(1'b0); step(1'b0);
      chk("stop_valid", 64'(obs0_valid | obs1_valid), 64'd0);
      chk("stop_score_held", 64'(score), 64'd2);

      // Reset pulse mid-RUN with a live obstacle
      cur_gs = 1'b1;
      step(1'b0);
      wait_tick(n);
      step(1'b0);
      chk("live_before_rst", 64'(obs0_valid), 64'd1);
      step(1'b1);
      chk("rst_mid_run", 64'(dut_vec()), 64'd0);
      step(1'b0);
      wait_tick(n);
      chk("rerun_tick", 64'(n), 64'd4);

      // Overlap begins on a tick cycle: tick discarded
      for (int k = 0; k < 4000; k++) begin
         if (m_state == 1 && m_cnt == TICK_DIV - 1 && m_v[0] && m_x[0] == 70) break;
         step(1'b0);
      end
      chk("at_x70", 64'(obs0_x), 64'd70);
      cur_dh = 6'd0;
      step(1'b0);
      chk("coll_on_tick", 64'(collision), 64'd1);
      chk("tick_same_cycle", 64'(tick), 64'd1);
      step(1'b0);
      chk("coll_pulse_len", 64'(collision), 64'd0);
      chk("x_kept_on_hit", 64'(obs0_x), 64'd70);
      chk("score_kept_on_hit", 64'(score), 64'd0);
      for (int k = 0; k < 6; k++) step(1'b0);
      chk("hit_frozen", 64'(obs0_x), 64'd70);
      chk("hit_no_tick", 64'(tick), 64'd0);
      cur_gs = 1'b0;
      step(1'b0); step(1'b0);
      chk("hit_exit_valid", 64'(obs0_valid | obs1_valid), 64'd0);

      // Low dino: first hit at x=79, pulse of one cycle
      cur_gs = 1'b1;
      step(1'b0);
      for (int k = 0; k < 4000; k++) begin
         step(1'b0);
         if (collision) break;
      end
      chk("coll_found", 64'(collision), 64'd1);
      chk("coll_x79", 64'(obs0_x), 64'd79);
      step(1'b0);
      chk("coll_pulse_len2", 64'(collision), 64'd0);
      step(1'b0);
      chk("x_frozen79", 64'(obs0_x), 64'd79);
      cur_gs = 1'b0;
      step(1'b0); step(1'b0);
      chk("exit_hit_valid2", 64'(obs0_valid), 64'd0);
      chk("exit_hit_score", 64'(score), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
